// File: rtl/alu_seq_core.sv
// alu_seq_core: registered ALU with valid/ready handshake; shifts/rotates step one bit per clock.
// Define ALU_BARREL_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq_core #(
    parameter int WIDTH = 20,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             neg,
    output logic             ovf
);

    typedef enum logic [3:0] {
        OP_NOT  = 4'd0,  OP_AND  = 4'd1,  OP_OR   = 4'd2,  OP_XOR  = 4'd3,
        OP_SHR  = 4'd4,  OP_SHL  = 4'd5,  OP_ROR  = 4'd6,  OP_ROL  = 4'd7,
        OP_SWAP = 4'd8,  OP_INC  = 4'd9,  OP_DEC  = 4'd10, OP_ADD  = 4'd11,
        OP_ADDC = 4'd12, OP_SUB  = 4'd13, OP_SUBC = 4'd14, OP_CMP  = 4'd15
    } op_e;

`ifdef ALU_BARREL_EN
    typedef enum logic [0:0] { S_IDLE = 1'b0, S_DONE = 1'b1 } state_e;
`else
    typedef enum logic [1:0] { S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2 } state_e;
`endif

    localparam int             MSB       = WIDTH - 1;
    localparam logic [SHW:0]   WIDTH_CNT = (SHW + 1)'(WIDTH);
    localparam logic [WIDTH:0] ONE_EXT   = (WIDTH + 1)'(1);

    state_e           state;
    state_e           state_nxt;
    logic             accept;
    logic [SHW:0]     amt;
    logic [SHW:0]     shift_steps;
    logic [SHW:0]     rot_steps;
    logic [WIDTH-1:0] comb_result;
    logic [WIDTH-1:0] flag_src;
    logic             comb_zero;
    logic             comb_carry;
    logic             comb_neg;
    logic             comb_ovf;
    logic [WIDTH:0]   arith;
    logic [WIDTH:0]   cin_ext;

`ifdef ALU_BARREL_EN
    logic [WIDTH:0]     sh_ext;
    logic [2*WIDTH-1:0] sh_wide;
`else
    localparam logic [SHW:0] CNT_ONE = (SHW + 1)'(1);

    logic             is_shift;
    logic             go_exec;
    logic [SHW:0]     steps;
    logic [SHW:0]     count;
    logic [1:0]       shift_op;
    logic [WIDTH-1:0] step_val;
    logic             step_out;
`endif

    assign accept  = in_valid && in_ready;
    assign cin_ext = {{WIDTH{1'b0}}, carry_in};

    // Shifts saturate at WIDTH; rotates wrap. amt < 2*WIDTH, so one conditional subtract suffices.
    assign amt         = {1'b0, b[SHW-1:0]};
    assign shift_steps = (amt >= WIDTH_CNT) ? WIDTH_CNT : amt;
    assign rot_steps   = (amt >= WIDTH_CNT) ? (amt - WIDTH_CNT) : amt;

    always_comb begin
        comb_result = a;
        comb_carry  = 1'b0;
        comb_ovf    = 1'b0;
        arith       = '0;
`ifdef ALU_BARREL_EN
        sh_ext      = '0;
        sh_wide     = '0;
`endif
        unique case (op)
            OP_NOT:  comb_result = ~a;
            OP_AND:  comb_result = a & b;
            OP_OR:   comb_result = a | b;
            OP_XOR:  comb_result = a ^ b;
`ifdef ALU_BARREL_EN
            OP_SHR: begin
                sh_ext      = {a, 1'b0} >> shift_steps;
                comb_result = sh_ext[WIDTH:1];
                comb_carry  = sh_ext[0];
            end
            OP_SHL: begin
                sh_ext      = {1'b0, a} << shift_steps;
                comb_result = sh_ext[WIDTH-1:0];
                comb_carry  = sh_ext[WIDTH];
            end
            OP_ROR: begin
                sh_wide     = {a, a} >> rot_steps;
                comb_result = sh_wide[WIDTH-1:0];
            end
            OP_ROL: begin
                sh_wide     = {a, a} << rot_steps;
                comb_result = sh_wide[2*WIDTH-1:WIDTH];
            end
`else
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: comb_result = a;
`endif
            OP_SWAP: comb_result = {a[WIDTH/2-1:0], a[WIDTH-1:WIDTH/2]};
            OP_INC: begin
                arith       = {1'b0, a} + ONE_EXT;
                comb_result = arith[WIDTH-1:0];
                comb_carry  = arith[WIDTH];
                comb_ovf    = ~a[MSB] & arith[MSB];
            end
            OP_DEC: begin
                arith       = {1'b0, a} - ONE_EXT;
                comb_result = arith[WIDTH-1:0];
                comb_carry  = arith[WIDTH];
                comb_ovf    = a[MSB] & ~arith[MSB];
            end
            OP_ADD, OP_ADDC: begin
                arith       = {1'b0, a} + {1'b0, b} + ((op == OP_ADDC) ? cin_ext : '0);
                comb_result = arith[WIDTH-1:0];
                comb_carry  = arith[WIDTH];
                comb_ovf    = (a[MSB] == b[MSB]) && (arith[MSB] != a[MSB]);
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                // Compare reuses the subtractor but keeps a as the visible result.
                arith       = {1'b0, a} - {1'b0, b} - ((op == OP_SUBC) ? cin_ext : '0);
                comb_result = (op == OP_CMP) ? a : arith[WIDTH-1:0];
                comb_carry  = arith[WIDTH];
                comb_ovf    = (a[MSB] != b[MSB]) && (arith[MSB] != a[MSB]);
            end
        endcase
        flag_src  = (op == OP_CMP) ? arith[WIDTH-1:0] : comb_result;
        comb_zero = (flag_src == '0);
        comb_neg  = flag_src[MSB];
    end

`ifndef ALU_BARREL_EN
    assign is_shift = (op[3:2] == 2'b01);
    assign steps    = op[1] ? rot_steps : shift_steps;
    assign go_exec  = is_shift && (steps != '0);

    // One-bit shift of the working value; shift_op[1] selects rotate, shift_op[0] selects left.
    always_comb begin
        step_val = result;
        step_out = 1'b0;
        case (shift_op)
            2'b00: begin
                step_val = {1'b0, result[WIDTH-1:1]};
                step_out = result[0];
            end
            2'b01: begin
                step_val = {result[WIDTH-2:0], 1'b0};
                step_out = result[MSB];
            end
            2'b10:   step_val = {result[0], result[WIDTH-1:1]};
            default: step_val = {result[WIDTH-2:0], result[MSB]};
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef ALU_BARREL_EN
                    state_nxt = S_DONE;
`else
                    state_nxt = go_exec ? S_EXEC : S_DONE;
`endif
                end
            end
`ifndef ALU_BARREL_EN
            S_EXEC: begin
                if (count == CNT_ONE) begin
                    state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The result register doubles as the shift working register while in EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
`ifndef ALU_BARREL_EN
            count    <= '0;
            shift_op <= '0;
`endif
        end else if (accept) begin
            result   <= comb_result;
            zero     <= comb_zero;
            carry    <= comb_carry;
            neg      <= comb_neg;
            ovf      <= comb_ovf;
`ifndef ALU_BARREL_EN
            count    <= go_exec ? steps : '0;
            shift_op <= op[1:0];
`endif
        end
`ifndef ALU_BARREL_EN
        else if (state == S_EXEC) begin
            result <= step_val;
            carry  <= step_out;
            count  <= count - CNT_ONE;
            if (count == CNT_ONE) begin
                zero <= (step_val == '0);
                neg  <= step_val[MSB];
            end
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core at WIDTH=20: directed vectors with hand-computed results,
// handshake latency, result hold under back-pressure and reset during a running shift.
module tb_alu_seq_core;

    localparam int W = 20;
`ifdef ALU_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         neg;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .neg       (neg),
        .ovf       (ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Latency in edges counting the accept edge as 1.
    function automatic int shiftLat(input int n);
        return BARREL ? 1 : n + 1;
    endfunction

    // Presents one operation, then scrambles the inputs and counts edges until out_valid.
    task automatic applyStimulus(input logic [3:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                 input logic cin_i, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        op       = op_i;
        a        = a_i;
        b        = b_i;
        carry_in = cin_i;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = ~op_i;
        a        = ~a_i;
        b        = ~b_i;
        carry_in = ~cin_i;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic releaseResult(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "/released"}, {30'd0, out_valid, in_ready}, 32'h1);
    endtask

    // exp_f packs the flags as {zero, carry, neg, ovf}.
    task automatic doOp(input string tag, input logic [3:0] op_i, input logic [W-1:0] a_i,
                        input logic [W-1:0] b_i, input logic cin_i, input logic [W-1:0] exp_res,
                        input logic [3:0] exp_f, input int exp_lat);
        int lat;
        checkOutput({tag, "/idle"}, {31'd0, in_ready}, 32'h1);
        applyStimulus(op_i, a_i, b_i, cin_i, lat);
        checkOutput({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "/result"}, {12'd0, result}, {12'd0, exp_res});
        checkOutput({tag, "/flags"}, {28'd0, zero, carry, neg, ovf}, {28'd0, exp_f});
        checkOutput({tag, "/busy"}, {31'd0, in_ready}, 32'h0);
        releaseResult(tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to end earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", {6'd0, out_valid, in_ready, zero, carry, neg, ovf, result},
                    {6'd0, 1'b0, 1'b1, 4'b0000, 20'h00000});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] arithmetic and logic vectors");
        doOp("add_wrap",  4'd11, 20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 4'b1100, 1);
        doOp("add_nocin", 4'd11, 20'h00001, 20'h00002, 1'b1, 20'h00003, 4'b0000, 1);
        doOp("addc_ovf",  4'd12, 20'h7FFFF, 20'h00000, 1'b1, 20'h80000, 4'b0011, 1);
        doOp("sub_neg",   4'd13, 20'h00005, 20'h00007, 1'b0, 20'hFFFFE, 4'b0110, 1);
        doOp("sub_ovf",   4'd13, 20'h80000, 20'h00001, 1'b0, 20'h7FFFF, 4'b0001, 1);
        doOp("subc",      4'd14, 20'h00005, 20'h00003, 1'b1, 20'h00001, 4'b0000, 1);
        doOp("not",       4'd0,  20'h0F0F0, 20'h00000, 1'b0, 20'hF0F0F, 4'b0010, 1);
        doOp("and",       4'd1,  20'hFF00F, 20'h0F0F0, 1'b0, 20'h0F000, 4'b0000, 1);
        doOp("or",        4'd2,  20'hFF00F, 20'h0F0F0, 1'b0, 20'hFF0FF, 4'b0010, 1);
        doOp("xor",       4'd3,  20'hFF00F, 20'h0F0F0, 1'b0, 20'hF00FF, 4'b0010, 1);
        doOp("swap",      4'd8,  20'h12345, 20'h00000, 1'b0, 20'hD1448, 4'b0010, 1);
        doOp("inc_wrap",  4'd9,  20'hFFFFF, 20'h00000, 1'b0, 20'h00000, 4'b1100, 1);
        doOp("inc_ovf",   4'd9,  20'h7FFFF, 20'h00000, 1'b0, 20'h80000, 4'b0011, 1);
        doOp("dec_wrap",  4'd10, 20'h00000, 20'h00000, 1'b0, 20'hFFFFF, 4'b0110, 1);
        doOp("dec_ovf",   4'd10, 20'h80000, 20'h00000, 1'b0, 20'h7FFFF, 4'b0001, 1);
        doOp("cmp_ult",   4'd15, 20'h00001, 20'h00002, 1'b0, 20'h00001, 4'b0110, 1);
        doOp("cmp_slt",   4'd15, 20'h80000, 20'h00001, 1'b0, 20'h80000, 4'b0001, 1);

        $display("[TB] shift and rotate vectors");
        doOp("ror3",      4'd6,  20'h00001, 20'd3,     1'b0, 20'h20000, 4'b0000, shiftLat(3));
        doOp("shl25",     4'd5,  20'h80001, 20'd25,    1'b0, 20'h00000, 4'b1100, shiftLat(20));
        doOp("shr1",      4'd4,  20'h80001, 20'd1,     1'b0, 20'h40000, 4'b0100, shiftLat(1));
        doOp("shr0",      4'd4,  20'h80001, 20'd0,     1'b0, 20'h80001, 4'b0010, 1);
        doOp("shr20",     4'd4,  20'h80000, 20'd20,    1'b0, 20'h00000, 4'b1100, shiftLat(20));
        doOp("rol21",     4'd7,  20'h80000, 20'd21,    1'b0, 20'h00001, 4'b0000, shiftLat(1));
        doOp("rol4",      4'd7,  20'h12345, 20'd4,     1'b0, 20'h23451, 4'b0000, shiftLat(4));
        doOp("ror20",     4'd6,  20'h12345, 20'd20,    1'b0, 20'h12345, 4'b0000, 1);

        $display("[TB] result hold under back-pressure");
        applyStimulus(4'd15, 20'h00003, 20'h00003, 1'b0, lat);
        checkOutput("cmp_hold/lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op       = 4'd11;
            a        = 20'h11111;
            b        = 20'h22222;
            @(posedge clk);
            #1;
            checkOutput($sformatf("cmp_hold%0d", i), {6'd0, out_valid, in_ready, zero, carry, neg, ovf, result},
                        {6'd0, 1'b1, 1'b0, 4'b1000, 20'h00003});
        end
        in_valid = 1'b0;
        releaseResult("cmp_hold");

        $display("[TB] reset during a running rotate");
        @(negedge clk);
        in_valid = 1'b1;
        op       = 4'd6;
        a        = 20'h12345;
        b        = 20'd10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_exec", {6'd0, out_valid, in_ready, zero, carry, neg, ovf, result},
                    {6'd0, 1'b0, 1'b1, 4'b0000, 20'h00000});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        doOp("post_rst",  4'd11, 20'h00001, 20'h00002, 1'b0, 20'h00003, 4'b0000, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
